// File: rtl/hall_pkg.sv
// Shared definitions for the Hall-effect rotation front-end.
// Used by the speed meter, the slice PLL and the status/SPI readback.
//   SPEED_W      width of the turn period (clk ticks)
//   HALL_N       number of Hall sensors
//   HALL_REF     index of the turn-reference sensor
//   HALL_HALF    index of the half-turn sensor
//   hall_state_t measurement state: IDLE (stalled), ARMED (one edge seen), RUN (period current)
package hall_pkg;

    localparam int unsigned SPEED_W   = 32;
    localparam int unsigned HALL_N    = 2;
    localparam int unsigned HALF_CNT_W = 2;

    // One-bit indices so they select a bit of the 2-bit sensor bus without width truncation.
    localparam logic [0:0] HALL_REF  = 1'b0;
    localparam logic [0:0] HALL_HALF = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } hall_state_t;

    // Saturating increment for the per-turn sensor-1 edge counter.
    function automatic logic [HALF_CNT_W-1:0] sat_inc(input logic [HALF_CNT_W-1:0] v);
        if (v == {HALF_CNT_W{1'b1}}) begin
            return v;
        end
        return v + HALF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hall_speed_meter_debounce.sv
// Compatibility package for the speed-meter input path; the filter itself is in hall_debounce.
package hall_speed_meter_debounce_pkg;
    localparam int unsigned UNUSED_MARKER = 0;
endpackage

// File: rtl/hall_debounce.sv
// Input path for one raw Hall pin: 2-FF synchroniser, stability filter, falling-edge pulse.
//   clk, nrst  system clock, asynchronous active-low reset
//   pin        raw sensor pin (active low, asynchronous to clk)
//   fall       one-cycle pulse when the filtered level goes 1 -> 0
// Pin-to-pulse latency is fixed (2 sync stages + DEBOUNCE_CYCLES samples), so edge spacing
// is preserved exactly for clean inputs.
module hall_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic pin,
    output logic fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] run_cnt;

    // Synchroniser and filter; all flops reset to the inactive (high) level.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
            fall   <= 1'b0;
            if (sync_b == level) begin
                // Any sample agreeing with the current level restarts the run.
                run_cnt <= '0;
            end else if (run_cnt == LAST) begin
                // DEBOUNCE_CYCLES consecutive differing samples: take the new level.
                level   <= sync_b;
                run_cnt <= '0;
                fall    <= ~sync_b;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hall_speed_meter.sv
// Hall-sensor speed meter: debounces both sensors, times consecutive turn-reference edges
// and reports each completed turn to the slice PLL.
//   clk, nrst      system clock, asynchronous active-low reset
//   hall[1:0]      raw pins, active low; [0] turn reference, [1] half-turn sensor
//   speed_data     ticks between the two most recent accepted reference edges
//   start_of_turn  one-cycle pulse, speed_data updated in the same cycle
//   speed_valid    a measured period is current
//   stalled        no valid period (reset, timeout, or still re-arming)
//   turn_err       one-cycle pulse with start_of_turn when the half-turn sensor did not
//                  fire exactly once during the finished turn
module hall_speed_meter
    import hall_pkg::*;
#(
    parameter int unsigned        DEBOUNCE_CYCLES = 16,
    parameter logic [SPEED_W-1:0] MIN_PERIOD      = 32'd4096,
    parameter logic [SPEED_W-1:0] TIMEOUT         = 32'd100_000_000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [HALL_N-1:0]  hall,
    output logic [SPEED_W-1:0] speed_data,
    output logic               start_of_turn,
    output logic               speed_valid,
    output logic               stalled,
    output logic               turn_err
);

    logic [HALL_N-1:0]     fall;
    logic                  ref_edge;
    logic                  half_edge;
    hall_state_t           state;
    logic [SPEED_W-1:0]    cnt;
    logic [HALF_CNT_W-1:0] half_cnt;

    hall_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_ref (
        .clk  (clk),
        .nrst (nrst),
        .pin  (hall[HALL_REF]),
        .fall (fall[HALL_REF])
    );

    hall_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_half (
        .clk  (clk),
        .nrst (nrst),
        .pin  (hall[HALL_HALF]),
        .fall (fall[HALL_HALF])
    );

    assign ref_edge  = fall[HALL_REF];
    assign half_edge = fall[HALL_HALF];

    // Measurement FSM with period counter, half-turn counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            cnt           <= '0;
            half_cnt      <= '0;
            speed_data    <= '0;
            start_of_turn <= 1'b0;
            speed_valid   <= 1'b0;
            stalled       <= 1'b1;
            turn_err      <= 1'b0;
        end else begin
            start_of_turn <= 1'b0;
            turn_err      <= 1'b0;

            // Free-running defaults; the state cases below override on edges/timeout.
            if (state != IDLE && cnt != TIMEOUT) begin
                cnt <= cnt + SPEED_W'(1);
            end
            if (half_edge) begin
                half_cnt <= sat_inc(half_cnt);
            end

            case (state)
                IDLE: begin
                    if (ref_edge) begin
                        state    <= ARMED;
                        cnt      <= SPEED_W'(1);
                        half_cnt <= HALF_CNT_W'(half_edge);
                    end
                end
                ARMED, RUN: begin
                    if (ref_edge) begin
                        // An edge takes priority over a coincident timeout.
                        if (cnt >= MIN_PERIOD) begin
                            state         <= RUN;
                            cnt           <= SPEED_W'(1);
                            speed_data    <= cnt;
                            start_of_turn <= 1'b1;
                            speed_valid   <= 1'b1;
                            stalled       <= 1'b0;
                            // First accept after arming has no complete turn to check.
                            turn_err      <= (state == RUN) && (half_cnt != HALF_CNT_W'(1));
                            // A coincident half-turn edge belongs to the new turn.
                            half_cnt      <= HALF_CNT_W'(half_edge);
                        end
                    end else if (cnt == TIMEOUT) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        speed_data  <= '0;
                        speed_valid <= 1'b0;
                        stalled     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hall_speed_meter.sv
// Self-checking bench for hall_speed_meter (DEBOUNCE_CYCLES=4, MIN_PERIOD=200, TIMEOUT=5000).
module tb_hall_speed_meter;

    localparam int     DEB   = 4;
    localparam int     MINP  = 200;
    localparam int     TOUT  = 5000;
    localparam int     LAT   = 3 + DEB;

    logic        clk;
    logic        nrst;
    logic [1:0]  hall;
    logic [31:0] speed_data;
    logic        start_of_turn;
    logic        speed_valid;
    logic        stalled;
    logic        turn_err;

    hall_speed_meter #(
        .DEBOUNCE_CYCLES(DEB),
        .MIN_PERIOD     (32'd200),
        .TIMEOUT        (32'd5000)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .hall         (hall),
        .speed_data   (speed_data),
        .start_of_turn(start_of_turn),
        .speed_valid  (speed_valid),
        .stalled      (stalled),
        .turn_err     (turn_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nerr = 0;

    // One turn of stimulus plus the expectations for the reference edge that starts it.
    typedef struct {
        int          gap;
        int          k;
        bit          simul;
        int          gat;
        int          glen;
        int          stall_c;
        bit          chk;
        bit          e_sot;
        logic [31:0] e_sd;
        bit          e_err;
        bit          e_stl;
        bit          e_vld;
    } row_t;

    typedef struct {
        longint      t;
        logic [31:0] sd;
        bit          sot;
        bit          err;
        bit          stall;
        bit          sv;
        bit          stl;
    } ev_t;

    row_t   tbl[22];
    longint ref_q[$];
    longint half_q[$];
    ev_t    obs_q[$];
    ev_t    exp_q[$];
    bit     stl_d = 1'b1;

    function automatic row_t mk(int gap, int k, bit simul, int gat, int glen, int stall_c,
                                bit chk, bit s, logic [31:0] sd, bit e, bit stl, bit vld);
        row_t r;
        r.gap = gap; r.k = k; r.simul = simul; r.gat = gat; r.glen = glen;
        r.stall_c = stall_c; r.chk = chk;
        r.e_sot = s; r.e_sd = sd; r.e_err = e; r.e_stl = stl; r.e_vld = vld;
        return r;
    endfunction

    function automatic ev_t mk_ev(longint t, logic [31:0] sd, bit sot, bit err, bit stall,
                                  bit sv, bit stl);
        ev_t e;
        e.t = t; e.sd = sd; e.sot = sot; e.err = err; e.stall = stall; e.sv = sv; e.stl = stl;
        return e;
    endfunction

    function automatic logic [127:0] pack_ev(ev_t e);
        return {64'(e.t), e.sd, 27'd0, e.sot, e.err, e.stall, e.sv, e.stl};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observed turn reports and stall onsets, sampled on the falling edge.
    always @(negedge clk) begin
        if (nrst) begin
            if (start_of_turn || turn_err)
                obs_q.push_back(mk_ev(cyc, speed_data, start_of_turn, turn_err, 1'b0,
                                      speed_valid, stalled));
            if (stalled && !stl_d)
                obs_q.push_back(mk_ev(cyc, speed_data, start_of_turn, turn_err, 1'b1,
                                      speed_valid, stalled));
        end
        stl_d = stalled;
    end

    task automatic reset_dut();
        hall = 2'b11;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        ref_q.delete();
        half_q.delete();
        obs_q.delete();
        @(negedge clk);
        check("reset", 128'({speed_data, start_of_turn, speed_valid, stalled, turn_err}),
              128'({32'd0, 1'b0, 1'b0, 1'b1, 1'b0}));
    endtask

    // Drives one turn cycle by cycle; c counts falling edges since the reference pin fell.
    task automatic run_row(input row_t r);
        bit h0;
        bit h1;
        bit stray;
        int pos;
        stray = 1'b0;
        for (int c = 0; c < r.gap; c++) begin
            @(negedge clk);
            if (r.chk) begin
                if (c == LAT)
                    check("turn", 128'({start_of_turn, speed_data, turn_err, stalled, speed_valid}),
                          128'({r.e_sot, r.e_sd, r.e_err, r.e_stl, r.e_vld}));
                else if (start_of_turn || turn_err)
                    stray = 1'b1;
                if (r.stall_c != 0 && c == r.stall_c - 1)
                    check("pre_stall", 128'(stalled), 128'(1'b0));
                if (r.stall_c != 0 && c == r.stall_c)
                    check("stall", 128'({stalled, speed_valid, speed_data}),
                          128'({1'b1, 1'b0, 32'd0}));
            end
            h0 = !((c < 20) || (r.glen > 0 && c >= r.gat && c < r.gat + r.glen));
            h1 = !(r.simul && c < 10);
            for (int i = 0; i < r.k; i++) begin
                pos = (i + 1) * r.gap / (r.k + 1);
                if (c >= pos && c < pos + 10) h1 = 1'b0;
                if (c == pos) half_q.push_back(cyc);
            end
            if (r.simul && c == 0) half_q.push_back(cyc);
            if (c == 0) ref_q.push_back(cyc);
            if (r.glen >= 8 && c == r.gat) ref_q.push_back(cyc);
            hall = {h1, h0};
        end
        if (r.chk) check("stray_pulse", 128'(stray), 128'(1'b0));
    endtask

    // Reference model on pin-edge timestamps: arm, accept/reject by distance, timeout,
    // half-turn edges counted over [previous accept, this edge).
    task automatic build_expected();
        int     st;
        longint last;
        longint t;
        int     n;
        st = 0;
        last = 0;
        exp_q.delete();
        foreach (ref_q[i]) begin
            t = ref_q[i];
            if (st != 0 && t - last > TOUT) begin
                if (st == 2) exp_q.push_back(mk_ev(last + LAT + TOUT, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
                st = 0;
            end
            if (st == 0) begin
                st = 1;
                last = t;
            end else if (t - last >= MINP) begin
                n = 0;
                foreach (half_q[j]) if (half_q[j] >= last && half_q[j] < t) n++;
                exp_q.push_back(mk_ev(t + LAT, 32'(t - last), 1'b1, (st == 2) && (n != 1),
                                      1'b0, 1'b1, 1'b0));
                st = 2;
                last = t;
            end
        end
        if (st == 2) exp_q.push_back(mk_ev(last + LAT + TOUT, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    endtask

    initial begin
        nrst = 1'b0;
        hall = 2'b11;

        //           gap  k  sim gat glen stall chk sot sd     err stl vld
        tbl[0]  = mk(1000, 1, 0, 0,   0,  0,    1,  0,  0,     0,  1,  0);
        tbl[1]  = mk(1000, 1, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[2]  = mk( 800, 0, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[3]  = mk(1200, 2, 0, 0,   0,  0,    1,  1,  800,   1,  0,  1);
        tbl[4]  = mk(1000, 1, 0, 0,   0,  0,    1,  1,  1200,  1,  0,  1);
        tbl[5]  = mk(1000, 1, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[6]  = mk( 199, 0, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[7]  = mk( 801, 1, 0, 0,   0,  0,    1,  0,  1000,  0,  0,  1);
        tbl[8]  = mk( 200, 0, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[9]  = mk(1000, 1, 0, 0,   0,  0,    1,  1,  200,   1,  0,  1);
        tbl[10] = mk(1000, 1, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[11] = mk(1000, 1, 0, 50,  10, 0,    1,  1,  1000,  0,  0,  1);
        tbl[12] = mk(1000, 1, 0, 300, 3,  0,    1,  1,  1000,  0,  0,  1);
        tbl[13] = mk(1000, 1, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[14] = mk(5200, 1, 0, 0,   0,  LAT + TOUT, 1, 1, 1000, 0, 0, 1);
        tbl[15] = mk(1000, 0, 0, 0,   0,  0,    1,  0,  0,     0,  1,  0);
        tbl[16] = mk(1000, 1, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[17] = mk(5000, 1, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[18] = mk(1000, 1, 0, 0,   0,  0,    1,  1,  5000,  0,  0,  1);
        tbl[19] = mk(1000, 0, 1, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[20] = mk(1000, 0, 0, 0,   0,  0,    1,  1,  1000,  0,  0,  1);
        tbl[21] = mk(1000, 0, 0, 0,   0,  0,    1,  1,  1000,  1,  0,  1);

        reset_dut();
        for (int i = 0; i < 22; i++) run_row(tbl[i]);

        // Reset asserted mid-turn between clock edges: outputs must clear at once.
        run_row(mk(300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("pre_async_reset", 128'({speed_valid, stalled}), 128'({1'b1, 1'b0}));
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset", 128'({speed_data, start_of_turn, speed_valid, stalled, turn_err}),
              128'({32'd0, 1'b0, 1'b0, 1'b1, 1'b0}));
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        run_row(mk(1000, 1, 0, 0, 0, 0, 1, 0, 0,    0, 1, 0));
        run_row(mk(1000, 1, 0, 0, 0, 0, 1, 1, 1000, 0, 0, 1));

        // Randomised turns against the timestamp model.
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            int gap;
            int k;
            int gat;
            int glen;
            gap = int'($urandom_range(80, 1000));
            if (i % 7 == 6) gap = int'($urandom_range(4995, 5005));
            k = int'($urandom_range(0, 3));
            gat = 0;
            glen = 0;
            if ($urandom_range(0, 4) == 0) begin
                glen = 10;
                gat = gap / 2;
            end
            run_row(mk(gap, k, 0, gat, glen, 0, 0, 0, 0, 0, 0, 0));
        end
        hall = 2'b11;
        repeat (TOUT + 200) @(negedge clk);
        build_expected();
        check("event_count", 128'(obs_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("event", pack_ev(obs_q[i]), pack_ev(exp_q[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
